// File: rtl/fifo_umbrales.sv
// fifo_umbrales: synchronous FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_ERR_STICKY_EN to make fifo_error sticky until reset or init.
module fifo_umbrales #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  init,
   input  logic [ADDR_WIDTH:0]   umbral_alto,
   input  logic [ADDR_WIDTH:0]   umbral_bajo,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  fifo_error
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0] count, alto_q, bajo_q;
   logic wr_en, rd_en, err;
   assign fifo_empty   = count == '0;
   assign fifo_full    = count == (ADDR_WIDTH+1)'(DEPTH);
   assign almost_full  = count >= alto_q;
   assign almost_empty = count <= bajo_q;
   // a pop on a full FIFO frees the slot the simultaneous push lands in
   assign wr_en = push && (!fifo_full || pop);
   assign rd_en = pop && !fifo_empty;
   assign err   = (push && fifo_full && !pop) || (pop && fifo_empty);
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         fifo_error <= 1'b0;
         alto_q     <= (ADDR_WIDTH+1)'(DEPTH - 1);
         bajo_q     <= CNT_ONE;
      end else begin
         if (init) begin
            alto_q <= umbral_alto;
            bajo_q <= umbral_bajo;
         end
         if (wr_en) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + PTR_ONE;
         end
         valid_out <= rd_en;
         count <= (wr_en && !rd_en) ? count + CNT_ONE : (!wr_en && rd_en) ? count - CNT_ONE : count;
`ifdef FIFO_ERR_STICKY_EN
         fifo_error <= init ? 1'b0 : (fifo_error || err);
`else
         fifo_error <= init ? 1'b0 : err;
`endif
      end
   end
endmodule

// File: doc/fifo_umbrales.md
Name: fifo_umbrales

Overview:
- Synchronous FIFO with programmable almost-full / almost-empty thresholds (umbrales), instantiated once per main FIFO, per VC FIFO and per D FIFO.
- Acts as the opposite end of the QoS control FSM: it accepts the threshold values the FSM drives during init.
- Returns the empty and error flags that the FSM consumes (FIFO_EMPTIES / FIFO_ERRORS bits).
- Its almost_full / almost_empty outputs feed flow-control pause logic.

Parameters:
- DATA_WIDTH, 6, word width.
- ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH (4).

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous, active-high; clears pointers, count, flags and thresholds.
- init  input  1  when high, latch umbral_alto/umbral_bajo on this edge.
- umbral_alto  input  ADDR_WIDTH+1  almost-full threshold (count level).
- umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold (count level).
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data.
- pop  input  1  read request.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out valid; 1-cycle pulse per accepted pop.
- fifo_empty  output  1  count == 0.
- fifo_full  output  1  count == DEPTH.
- almost_full  output  1  count >= umbral_alto_q.
- almost_empty  output  1  count <= umbral_bajo_q.
- fifo_error  output  1  overflow/underflow indication.

Behaviour:
- Storage: DEPTH x DATA_WIDTH register array.
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally modulo DEPTH.
  - count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Reset values (synchronous, takes priority over all else, including mid-transfer):
  - wr_ptr = rd_ptr = count = 0; data_out = 0; valid_out = 0; fifo_error = 0.
  - umbral_alto_q = DEPTH-1; umbral_bajo_q = 1.
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0.
  - Array contents need not be cleared.
- Threshold load:
  - init=1 latches umbral_alto_q <= umbral_alto and umbral_bajo_q <= umbral_bajo.
  - init=1 also clears fifo_error.
  - Push/pop are still serviced during init.
  - New thresholds take effect on flags the cycle after latching.
- Flags: fifo_empty, fifo_full, almost_full and almost_empty are combinational from the registered count and thresholds.
  - Comparisons are unsigned.
  - umbral_alto_q = 0 makes almost_full constantly 1.
  - umbral_bajo_q >= DEPTH makes almost_empty constantly 1.
- Write: push && !fifo_full writes mem[wr_ptr] <= data_in and increments wr_ptr.
- Read: pop && !fifo_empty registers data_out <= mem[rd_ptr], increments rd_ptr and sets valid_out=1 next cycle. Latency from pop to valid_out is 1 clock.
  - valid_out=0 on cycles without an accepted pop.
  - data_out holds its last value when no read occurs.
- Simultaneous push+pop:
  - Not empty and not full: both occur; count unchanged.
  - Full: both occur (the read frees a slot); count stays DEPTH; no error.
  - Empty: write occurs, pop is rejected (no fall-through); count becomes 1; underflow error.
- Overflow: push && fifo_full && !pop. Write dropped, pointers/count unchanged, error raised.
- Underflow: pop && fifo_empty. No read, valid_out=0, error raised.
- Error timing: fifo_error asserts on the clock edge following the offending cycle (registered).

Optional Feature:
- Macro FIFO_ERR_STICKY_EN.
- Defined: fifo_error is sticky. Once set it stays 1 until reset or init.
- Undefined: fifo_error is a 1-cycle pulse for each offending cycle. Back-to-back offences hold it high continuously.

Test Plan:
- Reset, then 4 pushes 0x01..0x04 with no pop -> count 1,2,3,4. almost_full rises when count reaches 3; fifo_full=1 after the 4th; fifo_empty falls after the first push.
- From full, 5th push of 0x05 -> write dropped, fifo_error=1 next cycle. Then 4 pops -> data_out 0x01..0x04 each with valid_out 1 cycle after its pop; fifo_empty=1 at end.
- Pop while empty -> valid_out stays 0, fifo_error=1. With FIFO_ERR_STICKY_EN it stays 1 until init pulse; without, it drops after 1 cycle.
- init=1 with umbral_alto=2, umbral_bajo=0 -> after 2 pushes almost_full=1. almost_empty=1 only when count=0.
- When full, push 0x3F + pop together -> data_out=oldest word, count stays 4, no error. Pointers wrap and later pops return 0x3F last.
- Push 0x2A + pop on empty FIFO -> count=1, fifo_error=1, valid_out=0. Next pop returns 0x2A. Assert reset mid-sequence -> all outputs return to reset values next edge.
